// File: rtl/jtdd_prom_we.sv
// ROM download front-end for JTDD: turns the ioctl byte stream into SDRAM write
// requests and priority-PROM strobes. Optional running checksum: JTDD_DWN_CHECKSUM_EN.
module jtdd_prom_we #(
    parameter logic [21:0] SCR_START  = 22'h05_8000,
    parameter logic [21:0] OBJ_START  = 22'h09_8000,
    parameter logic [21:0] PROM_START = 22'h0D_8000,
    parameter logic [21:0] SCR_WORD   = 22'h04_0000,
    parameter logic [21:0] OBJ_WORD   = 22'h08_0000,
    parameter int          TAIL       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    input  logic        sdram_ack,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    output logic        prom_prio_we,
    output logic        dwnld_busy,
    output logic        overrun
`ifdef JTDD_DWN_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    localparam int TW = $clog2(TAIL + 1);

    state_t         r_state;
    logic [21:0]    r_prog_addr;
    logic [7:0]     r_prog_data;
    logic [1:0]     r_prog_mask;
    logic           r_prog_we;
    logic           r_prom_we;
    logic           r_busy;
    logic           r_overrun;
    logic           r_dl;
    logic [TW-1:0]  r_tail;

    // One-entry SDRAM buffer and one-entry deferred PROM slot
    logic           r_buf_vld;
    logic [21:0]    r_buf_addr;
    logic [7:0]     r_buf_data;
    logic [1:0]     r_buf_mask;
    logic           r_pdef_vld;
    logic [7:0]     r_pdef_idx;
    logic [7:0]     r_pdef_data;

    logic           w_stb;
    logic           w_in_scr;
    logic           w_in_obj;
    logic           w_is_sdram;
    logic           w_is_prom;
    logic           w_sdram_stb;
    logic           w_prom_stb;
    logic [21:0]    w_scr_off;
    logic [21:0]    w_obj_off;
    logic [21:0]    w_word;
    logic [1:0]     w_mask;
    logic           w_req;
    logic           w_go_idle;
    logic           w_buf_drop;
    logic           w_prom_drop;
    logic           w_next_req;
    logic           w_next_buf;
    logic           w_fall;
    logic           w_rise;
    logic [TW-1:0]  w_next_tail;

    assign w_stb       = ioctl_wr & downloading;
    assign w_is_sdram  = ioctl_addr < PROM_START;
    assign w_is_prom   = (ioctl_addr >= PROM_START) && (ioctl_addr < PROM_START + 22'd256);
    assign w_in_scr    = (ioctl_addr >= SCR_START) && (ioctl_addr < OBJ_START);
    assign w_in_obj    = (ioctl_addr >= OBJ_START) && w_is_sdram;
    assign w_sdram_stb = w_stb & w_is_sdram;
    assign w_prom_stb  = w_stb & w_is_prom;
    assign w_scr_off   = ioctl_addr - SCR_START;
    assign w_obj_off   = ioctl_addr - OBJ_START;
    assign w_mask      = ioctl_addr[0] ? 2'b01 : 2'b10;

    // NOTE: w_word gets a default before the conditional overrides, so no latch is inferred.
    always_comb begin
        w_word = {1'b0, ioctl_addr[21:1]};
        if (w_in_obj) begin
            w_word = OBJ_WORD + (w_obj_off >> 1);
        end else if (w_in_scr) begin
            w_word = SCR_WORD + (w_scr_off >> 1);
        end
    end

    assign w_req       = (r_state == S_REQ);
    assign w_go_idle   = w_req & sdram_ack & ~r_buf_vld & ~w_sdram_stb;
    assign w_buf_drop  = w_req & ~sdram_ack & r_buf_vld & w_sdram_stb;
    assign w_prom_drop = w_req & r_pdef_vld & w_prom_stb;
    assign w_next_req  = w_req ? ~w_go_idle : w_sdram_stb;
    assign w_next_buf  = w_req & (sdram_ack ? (r_buf_vld & w_sdram_stb)
                                            : (r_buf_vld | w_sdram_stb));
    assign w_fall      = r_dl & ~downloading;
    assign w_rise      = ~r_dl & downloading;
    assign w_next_tail = w_fall            ? TW'(TAIL) :
                         (r_tail != '0)    ? r_tail - TW'(1) : '0;

    // NOTE: every register here uses <= so all branches see the pre-edge values of each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_prog_mask <= 2'b11;
            r_prog_we   <= 1'b0;
            r_prom_we   <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_dl        <= 1'b0;
            r_tail      <= '0;
            r_buf_vld   <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
            r_buf_mask  <= 2'b11;
            r_pdef_vld  <= 1'b0;
            r_pdef_idx  <= '0;
            r_pdef_data <= '0;
        end else begin
            r_dl      <= downloading;
            r_tail    <= w_next_tail;
            r_prom_we <= 1'b0;
            // Registered from next-state terms so the cycle where downloading falls stays covered
            r_busy    <= downloading | w_next_req | w_next_buf | (w_next_tail != '0);
            if (w_buf_drop || w_prom_drop) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_sdram_stb) begin
                        r_prog_addr <= w_word;
                        r_prog_data <= ioctl_data;
                        r_prog_mask <= w_mask;
                        r_prog_we   <= 1'b1;
                        r_state     <= S_REQ;
                    end else if (w_prom_stb) begin
                        r_prog_addr <= {14'd0, ioctl_addr[7:0]};
                        r_prog_data <= ioctl_data;
                        r_prom_we   <= 1'b1;
                    end
                end

                S_REQ: begin
                    if (sdram_ack) begin
                        if (r_buf_vld) begin
                            r_prog_addr <= r_buf_addr;
                            r_prog_data <= r_buf_data;
                            r_prog_mask <= r_buf_mask;
                            r_buf_vld   <= w_sdram_stb;
                            if (w_sdram_stb) begin
                                r_buf_addr <= w_word;
                                r_buf_data <= ioctl_data;
                                r_buf_mask <= w_mask;
                            end
                        end else if (w_sdram_stb) begin
                            r_prog_addr <= w_word;
                            r_prog_data <= ioctl_data;
                            r_prog_mask <= w_mask;
                        end else begin
                            r_prog_we   <= 1'b0;
                            r_prog_mask <= 2'b11;
                            r_state     <= S_IDLE;
                            // The SDRAM write is done, so a waiting PROM byte may now take prog_addr
                            if (r_pdef_vld) begin
                                r_prog_addr <= {14'd0, r_pdef_idx};
                                r_prog_data <= r_pdef_data;
                                r_prom_we   <= 1'b1;
                                r_pdef_vld  <= 1'b0;
                            end else if (w_prom_stb) begin
                                r_prog_addr <= {14'd0, ioctl_addr[7:0]};
                                r_prog_data <= ioctl_data;
                                r_prom_we   <= 1'b1;
                            end
                        end
                    end else if (w_sdram_stb && !r_buf_vld) begin
                        r_buf_addr <= w_word;
                        r_buf_data <= ioctl_data;
                        r_buf_mask <= w_mask;
                        r_buf_vld  <= 1'b1;
                    end

                    if (w_prom_stb && !r_pdef_vld && !w_go_idle) begin
                        r_pdef_idx  <= ioctl_addr[7:0];
                        r_pdef_data <= ioctl_data;
                        r_pdef_vld  <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef JTDD_DWN_CHECKSUM_EN
    logic        w_accept;
    logic [15:0] r_sum;

    assign w_accept = (w_sdram_stb & ~w_buf_drop) | (w_prom_stb & ~w_prom_drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else begin
            r_sum <= (w_rise ? 16'd0 : r_sum) + (w_accept ? {8'd0, ioctl_data} : 16'd0);
        end
    end

    assign checksum = r_sum;
`else
    logic w_rise_unused;
    assign w_rise_unused = w_rise;
`endif

    assign prog_addr    = r_prog_addr;
    assign prog_data    = r_prog_data;
    assign prog_mask    = r_prog_mask;
    assign prog_we      = r_prog_we;
    assign prom_prio_we = r_prom_we;
    assign dwnld_busy   = r_busy;
    assign overrun      = r_overrun;

endmodule

// File: tb/tb_jtdd_prom_we.sv
// Bench for jtdd_prom_we: directed cases with literal expectations plus random
// traffic compared every cycle against a queue-based model of the download path.
module tb_jtdd_prom_we;

    localparam logic [21:0] SCR_START  = 22'h05_8000;
    localparam logic [21:0] OBJ_START  = 22'h09_8000;
    localparam logic [21:0] PROM_START = 22'h0D_8000;
    localparam logic [21:0] SCR_WORD   = 22'h04_0000;
    localparam logic [21:0] OBJ_WORD   = 22'h08_0000;
    localparam int          TAIL       = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic [21:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic        sdram_ack = 1'b0;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prom_prio_we;
    logic        dwnld_busy;
    logic        overrun;
`ifdef JTDD_DWN_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    jtdd_prom_we dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .downloading  (downloading),
        .ioctl_addr   (ioctl_addr),
        .ioctl_data   (ioctl_data),
        .ioctl_wr     (ioctl_wr),
        .sdram_ack    (sdram_ack),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .prog_mask    (prog_mask),
        .prog_we      (prog_we),
        .prom_prio_we (prom_prio_we),
        .dwnld_busy   (dwnld_busy),
        .overrun      (overrun)
`ifdef JTDD_DWN_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } wr_t;

    wr_t         q[$];      // head is on the SDRAM port, second entry is buffered
    wr_t         pq[$];     // PROM byte waiting for the SDRAM port to go idle
    logic [21:0] m_addr = '0;
    logic [7:0]  m_data = '0;
    logic [1:0]  m_mask = 2'b11;
    logic        m_we = 1'b0;
    logic        m_prom = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_ovr = 1'b0;
    logic [15:0] m_sum = '0;
    logic        m_prev_dl = 1'b0;
    int          m_fall_age = 1000;
    bit          cmp_en = 0;

    // 0 = SDRAM word, 1 = PROM, 2 = discarded
    function automatic int classify(input logic [21:0] a, output logic [21:0] word);
        int unsigned ua;
        ua = a;
        word = '0;
        if (ua < 32'h05_8000)      begin word = 22'(ua / 2); return 0; end
        else if (ua < 32'h09_8000) begin word = 22'(32'h04_0000 + (ua - 32'h05_8000) / 2); return 0; end
        else if (ua < 32'h0D_8000) begin word = 22'(32'h08_0000 + (ua - 32'h09_8000) / 2); return 0; end
        else if (ua < 32'h0D_8100) begin word = 22'(ua % 256); return 1; end
        return 2;
    endfunction

    task automatic model_step();
        bit          was_req;
        bit          emit;
        int          kind;
        logic [21:0] word;
        wr_t         e;
        was_req = (q.size() > 0);
        emit = 0;
        if (downloading && !m_prev_dl) m_sum = 16'd0;
        if (was_req && sdram_ack) void'(q.pop_front());
        if (ioctl_wr && downloading) begin
            kind = classify(ioctl_addr, word);
            e.addr = word;
            e.data = ioctl_data;
            e.mask = ioctl_addr[0] ? 2'b01 : 2'b10;
            if (kind == 0) begin
                if (q.size() < 2) begin q.push_back(e); m_sum += 16'(ioctl_data); end
                else m_ovr = 1'b1;
            end else if (kind == 1) begin
                if (was_req) begin
                    if (pq.size() != 0) m_ovr = 1'b1;
                    else begin pq.push_back(e); m_sum += 16'(ioctl_data); end
                end else begin
                    m_addr = e.addr; m_data = e.data; emit = 1;
                    m_sum += 16'(ioctl_data);
                end
            end
        end
        if (q.size() == 0 && pq.size() != 0) begin
            e = pq.pop_front();
            m_addr = e.addr; m_data = e.data; emit = 1;
        end
        if (q.size() > 0) begin
            m_addr = q[0].addr; m_data = q[0].data; m_mask = q[0].mask; m_we = 1'b1;
        end else begin
            m_mask = 2'b11; m_we = 1'b0;
        end
        m_prom = emit;
        if (m_prev_dl && !downloading) m_fall_age = 0;
        else if (m_fall_age < 1000) m_fall_age++;
        m_busy = downloading || (q.size() > 0) || (m_fall_age < TAIL);
        m_prev_dl = downloading;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete(); pq.delete();
            m_addr = '0; m_data = '0; m_mask = 2'b11; m_we = 1'b0; m_prom = 1'b0;
            m_busy = 1'b0; m_ovr = 1'b0; m_sum = '0; m_prev_dl = 1'b0; m_fall_age = 1000;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("prog_we", prog_we, m_we);
            check("prog_addr", prog_addr, m_addr);
            check("prog_data", prog_data, m_data);
            check("prog_mask", prog_mask, m_mask);
            check("prom_prio_we", prom_prio_we, m_prom);
            check("dwnld_busy", dwnld_busy, m_busy);
            check("overrun", overrun, m_ovr);
`ifdef JTDD_DWN_CHECKSUM_EN
            check("checksum", checksum, m_sum);
`endif
        end
    end

    function automatic logic [21:0] rand_addr();
        case ($urandom_range(0, 9))
            0: return 22'($urandom_range(0, 32'h05_7FFF));
            1: return SCR_START - 22'd2 + 22'($urandom_range(0, 3));
            2: return OBJ_START - 22'd2 + 22'($urandom_range(0, 3));
            3: return PROM_START - 22'd2 + 22'($urandom_range(0, 3));
            4: return PROM_START + 22'($urandom_range(0, 255));
            5: return PROM_START + 22'd254 + 22'($urandom_range(0, 3));
            6: return 22'($urandom);
            7: return SCR_START + 22'($urandom_range(0, 32'h3_FFFF));
            8: return OBJ_START + 22'($urandom_range(0, 32'h3_FFFF));
            default: return 22'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic strobe(input logic [21:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_data = d;
    endtask

    initial begin
        tick();
        tick();
        check("reset prog_we", prog_we, 1'b0);
        check("reset prog_addr", prog_addr, 22'd0);
        check("reset prog_mask", prog_mask, 2'b11);
        check("reset busy", dwnld_busy, 1'b0);
        check("reset overrun", overrun, 1'b0);
        cmp_en = 1;
        rst_n = 1'b1;
        downloading = 1'b1;
        tick();

        // Low-region odd byte held until ack
        strobe(22'h00_0001, 8'hA5);
        tick();
        ioctl_wr = 1'b0;
        check("t1 we", prog_we, 1'b1);
        check("t1 addr", prog_addr, 22'h0);
        check("t1 mask", prog_mask, 2'b01);
        check("t1 data", prog_data, 8'hA5);
        repeat (4) tick();
        check("t1 we held", prog_we, 1'b1);
        check("t1 data held", prog_data, 8'hA5);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        check("t1 we after ack", prog_we, 1'b0);
        check("t1 mask after ack", prog_mask, 2'b11);

        // Scroll and object relocation
        strobe(22'h05_8002, 8'h3C);
        tick();
        ioctl_wr = 1'b0;
        check("scr addr", prog_addr, 22'h04_0001);
        check("scr mask", prog_mask, 2'b10);
        sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
        strobe(22'h09_8000, 8'h77);
        tick();
        ioctl_wr = 1'b0;
        check("obj addr", prog_addr, 22'h08_0000);
        sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;

        // PROM byte while idle
        strobe(22'h0D_8013, 8'h0C);
        tick();
        ioctl_wr = 1'b0;
        check("prom we", prom_prio_we, 1'b1);
        check("prom addr", prog_addr, 22'h13);
        check("prom data", prog_data, 8'h0C);
        check("prom no sdram", prog_we, 1'b0);
        tick();
        check("prom pulse end", prom_prio_we, 1'b0);

        // Three back-to-back strobes with ack low
        strobe(22'h00_0010, 8'h11); tick();
        strobe(22'h00_0011, 8'h22); tick();
        strobe(22'h00_0012, 8'h33); tick();
        ioctl_wr = 1'b0;
        check("ovr set", overrun, 1'b1);
        check("ovr head data", prog_data, 8'h11);
        check("ovr head addr", prog_addr, 22'h8);
        sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
        check("buf we", prog_we, 1'b1);
        check("buf data", prog_data, 8'h22);
        check("buf mask", prog_mask, 2'b01);
        sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
        check("buf done", prog_we, 1'b0);

        // Busy tail after downloading falls
        downloading = 1'b0;
        tick();
        for (int i = 0; i < TAIL; i++) begin
            check("tail busy", dwnld_busy, 1'b1);
            tick();
        end
        check("tail end", dwnld_busy, 1'b0);

        // Reset during a pending write
        downloading = 1'b1;
        tick();
        strobe(22'h00_0020, 8'h55);
        tick();
        ioctl_wr = 1'b0;
        check("pre-reset we", prog_we, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async reset we", prog_we, 1'b0);
        check("async reset overrun", overrun, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        // Random traffic against the model
        for (int i = 0; i < 5000; i++) begin
            ioctl_wr   = ($urandom_range(0, 2) == 0);
            ioctl_addr = rand_addr();
            ioctl_data = 8'($urandom);
            sdram_ack  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 299) == 0) downloading = ~downloading;
            tick();
        end
        ioctl_wr = 1'b0;
        sdram_ack = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
